blue_motion: RTL
================

// Module: blue_motion
// PURPOSE
//  Motion/state controller for the blue character, directly upstream of the blue sprite renderer.
//  Turns key inputs into character position, jump physics and the 3-bit state word
//  (bit0 facing 1=right, bit1 1=air, bit2 1=move). The renderer uses this state to select its sprite ROM.
//  Also maps the current VGA pixel to a 14-bit sprite ROM address and an in-sprite flag.
// PARAMETERS
//  SCREEN_W 640  visible width, pixels
//  SPR_W    47   sprite width; ROM address = row*SPR_W+col
//  SPR_H    60   sprite height, pixels
//  X_INIT   40   reset x (sprite left edge)
//  GROUND_Y 420  y of the sprite top edge when standing on the floor
//  STEP_X   2    horizontal pixels per tick
//  JUMP_V   12   initial upward speed, pixels/tick
//  GRAVITY  1    speed change per tick
//  VMAX     12   maximum fall speed
// PORTS
//  clk        in  1   system clock
//  rst        in  1   synchronous reset, active-high
//  tick       in  1   one-cycle physics-update strobe (frame rate)
//  key_left   in  1   level, move left
//  key_right  in  1   level, move right
//  key_jump   in  1   level, jump request
//  vga_x      in  10  current pixel column
//  vga_y      in  10  current pixel row
//  pos_x      out 10  sprite left edge
//  pos_y      out 10  sprite top edge
//  blue_state out 3   {move, air, facing}; feeds the renderer's state input
//  blue_addr  out 14  sprite ROM address for (vga_x, vga_y); feeds the renderer's address input
//  blue_hit   out 1   1 when (vga_x, vga_y) lies inside the sprite box
// BEHAVIOUR
//  Reset:
//   - pos_x=X_INIT, pos_y=GROUND_Y, vy=0, state GND_IDLE.
//   - blue_state=3'b001; blue_addr=0; blue_hit=0.
//   - jump_armed=1. Reset mid-jump returns to these values in one cycle.
//  No state change between ticks. Every update below happens on the cycle where tick=1.
//  FSM states: GND_IDLE, GND_MOVE, AIR_RISE, AIR_FALL.
//  Horizontal (all states):
//   - dir = right&~left ? +1 : left&~right ? -1 : 0.
//   - Both keys or neither: no motion, facing held.
//   - Otherwise facing := (dir==+1).
//   - pos_x moves by STEP_X, clamped to [0, SCREEN_W-SPR_W]. Use wide math; never wrap.
//   - At a clamp with a key held, pos_x stays put, but facing still updates.
//  GND_*:
//   - dir!=0 -> GND_MOVE, else GND_IDLE.
//   - If key_jump & jump_armed: vy:=JUMP_V, jump_armed:=0, go AIR_RISE.
//     The same tick applies no y change.
//  AIR_RISE:
//   - pos_y := max(pos_y-vy, 0).
//   - vy := vy-GRAVITY; if the new vy==0 or pos_y hit 0, then vy:=0 and go AIR_FALL.
//  AIR_FALL:
//   - vy := min(vy+GRAVITY, VMAX).
//   - pos_y := pos_y+vy; if this is >=GROUND_Y, then pos_y:=GROUND_Y, vy:=0,
//     and go GND_MOVE/GND_IDLE per dir.
//  jump_armed is set on any cycle with key_jump=0. A held jump key never re-jumps after landing.
//  blue_state:
//   - registered: bit0=facing, bit1=(state is AIR_*), bit2=(dir!=0).
//   - Updated with the state on the tick.
//  Address path (every clk, 1-cycle latency, independent of tick):
//   - hit = vga_x in [pos_x, pos_x+SPR_W) and vga_y in [pos_y, pos_y+SPR_H).
//   - blue_hit<=hit.
//   - blue_addr <= hit ? (vga_y-pos_y)*SPR_W+(vga_x-pos_x) : 0.
//   - Max address SPR_W*SPR_H-1 = 2819 fits 14 bits.
// TESTING
//  1. Reset held 2 clk, then release:
//     -> pos=(40,420), blue_state=001, blue_addr=0, blue_hit=0.
//  2. key_left, 5 ticks from x=40:
//     -> pos_x=30, blue_state=100. Hold for 20 more ticks -> pos_x=0, no wrap.
//  3. Tap key_jump on one tick:
//     -> state 011 at the next tick. Apex pos_y=420-78=342 after 12 rise ticks.
//     -> Lands with pos_y=420, blue_state=001. Total air time is bounded and deterministic.
//  4. key_jump held through landing:
//     -> no second jump. Release one clk, press again -> jump.
//  5. Both keys held -> pos_x unchanged, bit2=0, facing unchanged.
//     At x=593 with key_right -> stays at 593, bit0=1.
//  6. pos=(100,420):
//     -> vga=(100,420) gives blue_hit=1, addr=0 one clk later.
//     -> vga=(146,479) gives addr=2819.
//     -> vga=(147,420) gives blue_hit=0, addr=0.
//     Reset asserted mid-jump -> cycle after reset, test 1 values.

Source files
------------

// File: rtl/blue_motion_if.sv
// Blue character control and pixel-lookup bundle.
// Keys, tick and VGA scan in; position, state and sprite address out.
interface blue_motion_if;
  logic        tick;
  logic        key_left;
  logic        key_right;
  logic        key_jump;
  logic [9:0]  vga_x;
  logic [9:0]  vga_y;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic [2:0]  blue_state;
  logic [13:0] blue_addr;
  logic        blue_hit;

  modport master (
    output tick, key_left, key_right, key_jump,
    output vga_x, vga_y,
    input  pos_x, pos_y, blue_state,
    input  blue_addr, blue_hit
  );

  modport slave (
    input  tick, key_left, key_right, key_jump,
    input  vga_x, vga_y,
    output pos_x, pos_y, blue_state,
    output blue_addr, blue_hit
  );
endinterface

// File: rtl/blue_motion.sv
// Blue character motion controller: walking, jump physics, state word
// for the sprite renderer, and VGA pixel to sprite ROM address mapping.
module blue_motion #(
  parameter int SCREEN_W = 640,
  parameter int SPR_W    = 47,
  parameter int SPR_H    = 60,
  parameter int X_INIT   = 40,
  parameter int GROUND_Y = 420,
  parameter int STEP_X   = 2,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1,
  parameter int VMAX     = 12
) (
  input logic          clk,
  input logic          rst,
  blue_motion_if.slave bus
);
  localparam logic [10:0] X_MAX = 11'(SCREEN_W - SPR_W);
  localparam logic [10:0] STEP  = 11'(STEP_X);
  localparam logic [10:0] GND   = 11'(GROUND_Y);
  localparam logic [9:0]  X_RST = 10'(X_INIT);
  localparam logic [4:0]  V_JMP = 5'(JUMP_V);
  localparam logic [4:0]  V_G   = 5'(GRAVITY);
  localparam logic [4:0]  V_MAX = 5'(VMAX);

  typedef enum logic [1:0] {
    GND_IDLE, GND_MOVE, AIR_RISE, AIR_FALL
  } state_t;

  state_t      state, state_n;
  logic [9:0]  pos_x, pos_x_n;
  logic [9:0]  pos_y, pos_y_n;
  logic [4:0]  vy, vy_n;
  logic        facing, facing_n;
  logic        armed, armed_n;
  logic [2:0]  bstate, bstate_n;

  logic        go_r, go_l, moving;
  logic [10:0] x_add, x_sub;
  logic [10:0] y_rise, y_fall;
  logic        y_top;
  logic [4:0]  vy_dec, vy_inc, vy_cap;

  assign go_r   = bus.key_right & ~bus.key_left;
  assign go_l   = bus.key_left & ~bus.key_right;
  assign moving = go_r | go_l;

  // Wide arithmetic so clamps never see a wrapped value
  assign x_add  = {1'b0, pos_x} + STEP;
  assign x_sub  = {1'b0, pos_x} - STEP;
  assign y_rise = {1'b0, pos_y} - {6'd0, vy};
  assign y_top  = y_rise[10] | (y_rise == 11'd0);
  assign vy_dec = vy - V_G;
  assign vy_inc = vy + V_G;
  assign vy_cap = (vy_inc > V_MAX) ? V_MAX : vy_inc;
  assign y_fall = {1'b0, pos_y} + {6'd0, vy_cap};

  // Next-state and physics; everything but arming waits for tick
  always_comb begin
    state_n  = state;
    pos_x_n  = pos_x;
    pos_y_n  = pos_y;
    vy_n     = vy;
    facing_n = facing;
    armed_n  = armed | ~bus.key_jump;
    bstate_n = bstate;
    if (bus.tick) begin
      unique case (1'b1)
        go_r: begin
          facing_n = 1'b1;
          pos_x_n  = (x_add > X_MAX) ? X_MAX[9:0]
                                     : x_add[9:0];
        end
        go_l: begin
          facing_n = 1'b0;
          pos_x_n  = x_sub[10] ? 10'd0 : x_sub[9:0];
        end
        default: ;
      endcase
      unique case (state)
        GND_IDLE, GND_MOVE: begin
          state_n = moving ? GND_MOVE : GND_IDLE;
          if (bus.key_jump && armed) begin
            vy_n    = V_JMP;
            armed_n = 1'b0;
            state_n = AIR_RISE;
          end
        end
        AIR_RISE: begin
          pos_y_n = y_rise[10] ? 10'd0 : y_rise[9:0];
          vy_n    = vy_dec;
          if (vy_dec == 5'd0 || y_top) begin
            vy_n    = 5'd0;
            state_n = AIR_FALL;
          end
        end
        AIR_FALL: begin
          vy_n    = vy_cap;
          pos_y_n = y_fall[9:0];
          if (y_fall >= GND) begin
            pos_y_n = GND[9:0];
            vy_n    = 5'd0;
            state_n = moving ? GND_MOVE : GND_IDLE;
          end
        end
      endcase
      bstate_n = {moving, state_n[1], facing_n};
    end
  end

  // Motion registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= GND_IDLE;
      pos_x  <= X_RST;
      pos_y  <= GND[9:0];
      vy     <= 5'd0;
      facing <= 1'b1;
      armed  <= 1'b1;
      bstate <= 3'b001;
    end else begin
      state  <= state_n;
      pos_x  <= pos_x_n;
      pos_y  <= pos_y_n;
      vy     <= vy_n;
      facing <= facing_n;
      armed  <= armed_n;
      bstate <= bstate_n;
    end
  end

  logic [10:0] x_end, y_end;
  logic [9:0]  dx, dy;
  logic        hit;
  logic [13:0] addr;
  logic [13:0] addr_q;
  logic        hit_q;

  assign x_end = {1'b0, pos_x} + 11'(SPR_W);
  assign y_end = {1'b0, pos_y} + 11'(SPR_H);
  assign hit   = (bus.vga_x >= pos_x)
              && ({1'b0, bus.vga_x} < x_end)
              && (bus.vga_y >= pos_y)
              && ({1'b0, bus.vga_y} < y_end);
  assign dx    = bus.vga_x - pos_x;
  assign dy    = bus.vga_y - pos_y;
  assign addr  = 14'(dy) * 14'(SPR_W) + 14'(dx);

  // Pixel lookup, one clock behind the scan position
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= 1'b0;
      addr_q <= 14'd0;
    end else begin
      hit_q  <= hit;
      addr_q <= hit ? addr : 14'd0;
    end
  end

  assign bus.pos_x      = pos_x;
  assign bus.pos_y      = pos_y;
  assign bus.blue_state = bstate;
  assign bus.blue_addr  = addr_q;
  assign bus.blue_hit   = hit_q;
endmodule
